// File: rtl/instr_seq.sv
// Instruction sequencer: buffers up to DEPTH {word, hold} entries and plays them onto the core's instru port.
// Optional INSTR_SEQ_STALL_EN adds a stall input that freezes playback in place.
module instr_seq #(
  parameter int IW     = 32,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_data,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
`ifdef INSTR_SEQ_STALL_EN
  input  logic              stall,
`endif
  output logic [IW-1:0]     instru,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [AW-1:0] FIRST = '0;

  state_t            state;
  logic [AW-1:0]     rd_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              loop_q;

  logic [IW-1:0]     data_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];

  logic              stall_i;
  logic              wr_ok;
  logic              last;
  logic [AW-1:0]     nxt_idx;

`ifdef INSTR_SEQ_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign full    = (count == CW'(DEPTH));
  // A write only lands when neither clear nor start claims the cycle.
  assign wr_ok   = (state == IDLE) && !clear && !start && wr_en && !full;
  assign last    = (rd_idx == AW'(count - CW'(1)));
  assign nxt_idx = rd_idx + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_mem[count[AW-1:0]] <= wr_data;
      hold_mem[count[AW-1:0]] <= wr_hold;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      rd_idx      <= '0;
      hold_cnt    <= '0;
      loop_q      <= 1'b0;
      instru      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (clear) begin
            count <= '0;
          end else if (start) begin
            if (count != '0) begin
              state       <= PLAY;
              loop_q      <= loop;
              rd_idx      <= FIRST;
              hold_cnt    <= hold_mem[FIRST];
              instru      <= data_mem[FIRST];
              instr_valid <= 1'b1;
              busy        <= 1'b1;
            end
          end else if (wr_ok) begin
            count <= count + CW'(1);
          end
        end
        PLAY: begin
          if (stop) begin
            state       <= IDLE;
            instru      <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
          end else if (!stall_i) begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end else if (last) begin
              if (loop_q) begin
                rd_idx   <= FIRST;
                hold_cnt <= hold_mem[FIRST];
                instru   <= data_mem[FIRST];
              end else begin
                state       <= DONE;
                instru      <= '0;
                instr_valid <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
            end else begin
              rd_idx   <= nxt_idx;
              hold_cnt <= hold_mem[nxt_idx];
              instru   <= data_mem[nxt_idx];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq (DEPTH=4); stall scenario is built when INSTR_SEQ_STALL_EN is defined.
module tb_instr_seq;

  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int HOLD_W = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [IW-1:0]     wr_data;
  logic [HOLD_W-1:0] wr_hold;
  logic              clear;
  logic              start;
  logic              stop;
  logic              loop;
`ifdef INSTR_SEQ_STALL_EN
  logic              stall;
`endif
  logic [IW-1:0]     instru;
  logic              instr_valid;
  logic              busy;
  logic              done;
  logic              full;
  logic [CW-1:0]     count;

  int n_cmp = 0;
  int n_err = 0;

  instr_seq #(.IW(IW), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_hold(wr_hold),
    .clear(clear), .start(start), .stop(stop), .loop(loop),
`ifdef INSTR_SEQ_STALL_EN
    .stall(stall),
`endif
    .instru(instru), .instr_valid(instr_valid), .busy(busy), .done(done),
    .full(full), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] d, input logic [HOLD_W-1:0] h);
    wr_en = 1'b1; wr_data = d; wr_hold = h;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_play(input string tag, input logic [IW-1:0] exp);
    chk({tag, "_instru"}, 64'(instru), 64'(exp));
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_hold = '0;
    clear = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
`ifdef INSTR_SEQ_STALL_EN
    stall = 1'b0;
`endif
    #12;
    chk("rst_instru", 64'(instru), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    #5 rst = 1'b1;

    // one-shot playback
    wr(32'h8D084555, 16'd2);
    chk("os_count1", 64'(count), 64'd1);
    wr(32'h8D08455F, 16'd0);
    chk("os_count2", 64'(count), 64'd2);
    start = 1'b1; loop = 1'b0;
    tick();
    start = 1'b0;
    chk("os_busy", 64'(busy), 64'd1);
    chk_play("os_e0c0", 32'h8D084555);
    tick(); chk_play("os_e0c1", 32'h8D084555);
    tick(); chk_play("os_e0c2", 32'h8D084555);
    tick(); chk_play("os_e1c0", 32'h8D08455F);
    chk("os_nodone", 64'(done), 64'd0);
    tick();
    chk("os_done", 64'(done), 64'd1);
    chk("os_done_instru", 64'(instru), 64'd0);
    chk("os_done_valid", 64'(instr_valid), 64'd0);
    chk("os_done_busy", 64'(busy), 64'd0);
    tick();
    chk("os_done_pulse", 64'(done), 64'd0);

    // looping playback, then stop
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk_play($sformatf("loop_c%0d", i), (i % 4 < 3) ? 32'h8D084555 : 32'h8D08455F);
      chk($sformatf("loop_busy%0d", i), 64'(busy), 64'd1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 64'(instr_valid), 64'd0);
    chk("stop_instru", 64'(instru), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_done", 64'(done), 64'd0);
    chk("stop_count", 64'(count), 64'd2);

    // priority: clear beats start and wr_en
    clear = 1'b1; start = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD0000;
    tick();
    clear = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("pri_clr_count", 64'(count), 64'd0);
    chk("pri_clr_busy", 64'(busy), 64'd0);
    tick();
    chk("pri_clr_busy2", 64'(busy), 64'd0);
    wr(32'hA0000001, 16'd0);
    wr(32'hB0000002, 16'd0);
    start = 1'b1; wr_en = 1'b1; wr_data = 32'hC0000003; wr_hold = 16'd0;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk_play("pri_s_e0", 32'hA0000001);
    tick(); chk_play("pri_s_e1", 32'hB0000002);
    tick();
    chk("pri_s_done", 64'(done), 64'd1);
    chk("pri_s_count", 64'(count), 64'd2);

    // full / overflow
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("full_clr_count", 64'(count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      wr(32'hD0000000 + 32'(i), 16'd0);
      chk($sformatf("full_count%0d", i), 64'(count), 64'((i < 4) ? i + 1 : 4));
      chk($sformatf("full_flag%0d", i), 64'(full), 64'((i >= 3) ? 1 : 0));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk_play($sformatf("full_play%0d", i), 32'hD0000000 + 32'(i));
    end
    tick();
    chk("full_done", 64'(done), 64'd1);
    chk("full_done_instru", 64'(instru), 64'd0);
    tick();

    // asynchronous reset in the middle of looping playback
    start = 1'b1; loop = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    tick();
    chk_play("arst_pre", 32'hD0000001);
    #2 rst = 1'b0;
    #1;
    chk("arst_instru", 64'(instru), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    #2 rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst_start_busy", 64'(busy), 64'd0);
    chk("arst_start_valid", 64'(instr_valid), 64'd0);

`ifdef INSTR_SEQ_STALL_EN
    // stall freezes entry 0 and postpones done
    wr(32'hE0000000, 16'd1);
    wr(32'hE0000001, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_play("stl_c0", 32'hE0000000);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_play($sformatf("stl_frz%0d", i), 32'hE0000000);
      chk($sformatf("stl_nodone%0d", i), 64'(done), 64'd0);
    end
    stall = 1'b0;
    tick(); chk_play("stl_c6", 32'hE0000000);
    tick(); chk_play("stl_e1", 32'hE0000001);
    tick();
    chk("stl_done", 64'(done), 64'd1);
    chk("stl_done_valid", 64'(instr_valid), 64'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_seq.md
# instr_seq

Parametrised instruction sequencer that replaces hand-timed instruction drives into the processor `top`. It buffers up to DEPTH instruction words, each with its own hold count, then plays them onto the core's instruction input in order. It supports one-shot or looping playback, early stop, and an optional stall. It sits between bench or loader logic and the core's `instru` port.

## Interface
- IW, 32: instruction width in bits.
- DEPTH, 16: buffer entries (power of two, ≥2).
- HOLD_W, 16: hold-count width; each entry is presented for hold+1 cycles.
- CW = $clog2(DEPTH+1): derived width of `count`.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  append {wr_data, wr_hold} to buffer.
- wr_data  in  IW  instruction word to store.
- wr_hold  in  HOLD_W  extra cycles to hold this entry.
- clear  in  1  empty the buffer; honoured only in IDLE.
- start  in  1  begin playback; honoured only in IDLE with count>0.
- stop  in  1  abort playback; honoured in PLAY.
- loop  in  1  sampled with start; 1 selects wrap to entry 0 after the last entry.
- instru  out  IW  instruction presented to the core; 0 (NOP) when not valid.
- instr_valid  out  1  instru holds a buffered entry.
- busy  out  1  state is PLAY.
- done  out  1  one-cycle pulse when one-shot playback completes.
- full  out  1  count == DEPTH.
- count  out  CW  number of stored entries.

## Operation
- States: IDLE, PLAY, DONE.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - count, rd_idx, hold_cnt and the loop flag are cleared.
  - instru=0, instr_valid=0, busy=0, done=0, full=0.
  - Buffer contents are don't-care.
- IDLE:
  - wr_en with !full stores the entry at index count, and count increments.
  - wr_en while full is dropped; count is unchanged.
  - clear sets count to 0.
  - Priority is clear > start > wr_en; a lower-priority request in the same cycle is dropped.
  - start with count>0 latches loop and goes to PLAY with rd_idx=0 and hold_cnt=hold[0].
  - start with count=0 is ignored.
- PLAY:
  - instru = data[rd_idx] and instr_valid=1.
  - If hold_cnt>0, hold_cnt decrements.
  - Otherwise the sequencer advances: rd_idx+1, and hold_cnt is reloaded from the new entry.
  - At rd_idx == count-1 with hold_cnt == 0:
    - loop latched: rd_idx wraps to 0.
    - loop not latched: go to DONE.
  - stop goes to IDLE next cycle and takes priority over advance.
  - wr_en and clear are ignored in PLAY; the buffer is preserved for replay.
- DONE: done=1 for exactly one cycle, instru=0, instr_valid=0, then IDLE. The buffer is retained.
- Arithmetic: rd_idx is $clog2(DEPTH) bits. hold_cnt is HOLD_W bits and never underflows.

## Timing
- start accepted at edge N puts entry 0 on instru from edge N+1, a registered output with 1-cycle latency.
- Entry k is visible for exactly hold[k]+1 consecutive cycles, with no gap between entries or across loop wrap.
- One-shot playback of n entries gives total valid cycles = Σ(hold[k]+1).
- done is asserted in the cycle immediately after the last valid cycle.
- stop sampled at edge M gives instr_valid=0 and instru=0 from edge M+1.
- full and count update one cycle after the accepted write.
- rst assertion mid-PLAY clears all outputs immediately, without waiting for clk. Deassertion is synchronised externally; the first active edge sees IDLE.

## Configuration
- INSTR_SEQ_STALL_EN defined:
  - Adds input `stall` (1 bit).
  - While stall=1 in PLAY, hold_cnt and rd_idx freeze, and instru and instr_valid hold their values.
  - stop still overrides stall.
  - done is deferred until stall drops.
- INSTR_SEQ_STALL_EN undefined: no `stall` port exists, and playback is never paused.

## Test plan
- Reset: pulse rst=0 mid-PLAY → instru=0, instr_valid=0, count=0 asynchronously; start afterwards is ignored because count=0.
- One-shot: write 0x8D084555 (hold 2) and 0x8D08455F (hold 0), then start with loop=0 → 0x8D084555 for 3 cycles, 0x8D08455F for 1 cycle, then done pulses once and instru=0.
- Loop: same two entries with loop=1, run 12 cycles → pattern repeats every 4 cycles with no gap; stop → instr_valid=0 next cycle and busy=0.
- Full/overflow: with DEPTH=4, write 5 entries → full=1, count=4, fifth entry dropped; playback shows only the first 4.
- Priority: in IDLE, assert clear, start and wr_en together → count=0, no playback; start with wr_en → playback starts and the write is dropped.
- Stall (INSTR_SEQ_STALL_EN): stall=1 for 5 cycles during entry 0 with hold 1 → entry 0 is visible for 7 cycles total, and done is delayed by 5 cycles.
